// File: rtl/reorder_buffer_if.sv
// Issue, CDB, operand-query and commit bundle between the reservation station,
// the CDB, the register file / LSB and the reorder buffer.
interface reorder_buffer_if #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  logic              issue_valid;
  logic [1:0]        issue_type;
  logic [4:0]        issue_rd;
  logic [DATA_W-1:0] issue_pc;
  logic              issue_pred_taken;
  logic [TAG_W-1:0]  issue_tag;
  logic              full;
  logic              empty;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              cdb_taken;
  logic [DATA_W-1:0] cdb_target;

  logic [TAG_W-1:0]  query_j_tag;
  logic              query_j_ready;
  logic [DATA_W-1:0] query_j_value;
  logic [TAG_W-1:0]  query_k_tag;
  logic              query_k_ready;
  logic [DATA_W-1:0] query_k_value;

  logic              commit_valid;
  logic [4:0]        commit_rd;
  logic [DATA_W-1:0] commit_value;
  logic [TAG_W-1:0]  commit_tag;
  logic              commit_store;
  logic              flush;
  logic [DATA_W-1:0] flush_pc;

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
    input  issue_tag, full, empty,
    output cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
    output query_j_tag, query_k_tag,
    input  query_j_ready, query_j_value, query_k_ready, query_k_value,
    input  commit_valid, commit_rd, commit_value, commit_tag, commit_store,
    input  flush, flush_pc
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
    output issue_tag, full, empty,
    input  cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
    input  query_j_tag, query_k_tag,
    output query_j_ready, query_j_value, query_k_ready, query_k_value,
    output commit_valid, commit_rd, commit_value, commit_tag, commit_store,
    output flush, flush_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order commit queue: tags issued instructions, absorbs CDB results,
// answers operand lookups and retires in program order, flushing on mispredict.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int ROB_ADDR = 4,
  parameter int TAG_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  reorder_buffer_if.slave bus
);
  localparam logic [1:0] TYPE_REG  = 2'd0;
  localparam logic [1:0] TYPE_BR   = 2'd1;
  localparam logic [1:0] TYPE_ST   = 2'd2;
  localparam logic [1:0] TYPE_JALR = 2'd3;
  localparam int CW = ROB_ADDR + 1;

  logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;
  logic [ROB_SIZE-1:0] pred_q, pred_d, taken_q, taken_d;
  logic [1:0]          type_q   [ROB_SIZE];
  logic [1:0]          type_d   [ROB_SIZE];
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [4:0]          rd_d     [ROB_SIZE];
  logic [DATA_W-1:0]   pc_q     [ROB_SIZE];
  logic [DATA_W-1:0]   pc_d     [ROB_SIZE];
  logic [DATA_W-1:0]   value_q  [ROB_SIZE];
  logic [DATA_W-1:0]   value_d  [ROB_SIZE];
  logic [DATA_W-1:0]   target_q [ROB_SIZE];
  logic [DATA_W-1:0]   target_d [ROB_SIZE];

  logic [ROB_ADDR-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;

  logic                commit_valid_q, commit_valid_d;
  logic [4:0]          commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0]   commit_value_q, commit_value_d;
  logic [TAG_W-1:0]    commit_tag_q, commit_tag_d;
  logic                commit_store_q, commit_store_d;
  logic                flush_q, flush_d;
  logic [DATA_W-1:0]   flush_pc_q, flush_pc_d;

  logic                full_w, head_ready, head_mispredict;
  logic                do_commit, do_flush, do_issue, do_cdb, cdb_hit;
  logic [1:0]          head_type;
  logic [ROB_ADDR-1:0] cdb_idx, qj_idx, qk_idx;

  assign full_w     = (count_q == CW'(ROB_SIZE));
  assign bus.full   = full_w;
  assign bus.empty  = (count_q == '0);
  assign bus.issue_tag = TAG_W'(tail_q) + TAG_W'(1);

  assign head_type  = type_q[head_q];
  assign head_ready = busy_q[head_q] && ready_q[head_q];
  // jalr always redirects; a branch only when the resolved direction disagrees
  assign head_mispredict = (head_type == TYPE_JALR) ||
                           ((head_type == TYPE_BR) && (taken_q[head_q] != pred_q[head_q]));

  assign cdb_idx = ROB_ADDR'(bus.cdb_tag - TAG_W'(1));
  assign cdb_hit = bus.cdb_valid && (bus.cdb_tag != '0) &&
                   (bus.cdb_tag <= TAG_W'(ROB_SIZE)) && busy_q[cdb_idx];

  assign do_commit = rdy_in && head_ready;
  assign do_flush  = do_commit && head_mispredict;
  assign do_issue  = rdy_in && bus.issue_valid && !full_w && !do_flush;
  assign do_cdb    = rdy_in && cdb_hit && !do_flush;

  always_comb begin
    busy_d   = busy_q;
    ready_d  = ready_q;
    pred_d   = pred_q;
    taken_d  = taken_q;
    type_d   = type_q;
    rd_d     = rd_q;
    pc_d     = pc_q;
    value_d  = value_q;
    target_d = target_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q + CW'(do_issue) - CW'(do_commit);

    if (do_cdb) begin
      ready_d[cdb_idx]  = 1'b1;
      value_d[cdb_idx]  = bus.cdb_value;
      taken_d[cdb_idx]  = bus.cdb_taken;
      target_d[cdb_idx] = bus.cdb_target;
    end
    if (do_commit) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + ROB_ADDR'(1);
    end
    if (do_issue) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      type_d[tail_q]  = bus.issue_type;
      rd_d[tail_q]    = bus.issue_rd;
      pc_d[tail_q]    = bus.issue_pc;
      pred_d[tail_q]  = bus.issue_pred_taken;
      tail_d          = tail_q + ROB_ADDR'(1);
    end
    if (do_flush) begin
      busy_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Registered retire outputs: pulses last one cycle, payloads hold while stalled
  always_comb begin
    commit_valid_d = commit_valid_q;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_tag_d   = commit_tag_q;
    commit_store_d = commit_store_q;
    flush_d        = flush_q;
    flush_pc_d     = flush_pc_q;
    if (rdy_in) begin
      commit_valid_d = do_commit && ((head_type == TYPE_REG) || (head_type == TYPE_JALR));
      commit_store_d = do_commit && (head_type == TYPE_ST);
      flush_d        = do_flush;
      if (commit_valid_d) begin
        commit_rd_d    = rd_q[head_q];
        commit_value_d = value_q[head_q];
        commit_tag_d   = TAG_W'(head_q) + TAG_W'(1);
      end
      if (do_flush) begin
        if (head_type == TYPE_JALR || taken_q[head_q])
          flush_pc_d = target_q[head_q];
        else
          flush_pc_d = pc_q[head_q] + DATA_W'(4);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q         <= '0;
      ready_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      commit_store_q <= 1'b0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_tag_q   <= commit_tag_d;
      commit_store_q <= commit_store_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  always_ff @(posedge clk_in) begin
    pred_q   <= pred_d;
    taken_q  <= taken_d;
    type_q   <= type_d;
    rd_q     <= rd_d;
    pc_q     <= pc_d;
    value_q  <= value_d;
    target_q <= target_d;
  end

  // Operand lookup: tag 0 means no dependency; a same-cycle broadcast is forwarded
  assign qj_idx = ROB_ADDR'(bus.query_j_tag - TAG_W'(1));
  assign qk_idx = ROB_ADDR'(bus.query_k_tag - TAG_W'(1));

  always_comb begin
    bus.query_j_ready = ready_q[qj_idx];
    bus.query_j_value = value_q[qj_idx];
    if (bus.query_j_tag == '0) begin
      bus.query_j_ready = 1'b1;
      bus.query_j_value = '0;
    end else if (bus.cdb_valid && (bus.cdb_tag == bus.query_j_tag)) begin
      bus.query_j_ready = 1'b1;
      bus.query_j_value = bus.cdb_value;
    end
  end

  always_comb begin
    bus.query_k_ready = ready_q[qk_idx];
    bus.query_k_value = value_q[qk_idx];
    if (bus.query_k_tag == '0) begin
      bus.query_k_ready = 1'b1;
      bus.query_k_value = '0;
    end else if (bus.cdb_valid && (bus.cdb_tag == bus.query_k_tag)) begin
      bus.query_k_ready = 1'b1;
      bus.query_k_value = bus.cdb_value;
    end
  end

  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_rd    = commit_rd_q;
  assign bus.commit_value = commit_value_q;
  assign bus.commit_tag   = commit_tag_q;
  assign bus.commit_store = commit_store_q;
  assign bus.flush        = flush_q;
  assign bus.flush_pc     = flush_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based program-order model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_reorder_buffer;
  logic clk_in, rst_in, rdy_in;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 0;

  reorder_buffer_if rob ();

  reorder_buffer dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (rob)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic        rdy;
    logic [31:0] val;
    logic        tk;
    logic [31:0] tgt;
    logic [4:0]  tag;
  } ent_t;

  ent_t        mq[$];
  int          ntag = 1;
  logic        e_cv = 0, e_st = 0, e_fl = 0;
  logic [4:0]  e_rd = 0, e_tag = 0;
  logic [31:0] e_val = 0, e_fpc = 0;
  bit          m_com, m_fl, m_full_old;
  ent_t        m_h, m_new;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: a queue of in-flight instructions, oldest first
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mq.delete();
      ntag = 1;
      e_cv = 0; e_st = 0; e_fl = 0; e_rd = 0; e_tag = 0; e_val = 0; e_fpc = 0;
    end else if (rdy_in) begin
      m_com = (mq.size() > 0) && mq[0].rdy;
      m_fl = 0;
      e_cv = 0; e_st = 0;
      if (m_com) begin
        m_h = mq[0];
        if (m_h.typ == 0 || m_h.typ == 3) begin
          e_cv = 1; e_rd = m_h.rd; e_val = m_h.val; e_tag = m_h.tag;
        end
        if (m_h.typ == 2) e_st = 1;
        if (m_h.typ == 1 && m_h.tk != m_h.pred) begin
          m_fl = 1; e_fpc = m_h.tk ? m_h.tgt : m_h.pc + 32'd4;
        end
        if (m_h.typ == 3) begin m_fl = 1; e_fpc = m_h.tgt; end
      end
      e_fl = m_fl;
      if (m_fl) begin
        mq.delete();
        ntag = 1;
      end else begin
        if (rob.cdb_valid)
          foreach (mq[i])
            if (mq[i].tag == rob.cdb_tag) begin
              mq[i].rdy = 1; mq[i].val = rob.cdb_value;
              mq[i].tk = rob.cdb_taken; mq[i].tgt = rob.cdb_target;
            end
        m_full_old = (mq.size() == 16);
        if (m_com) void'(mq.pop_front());
        if (rob.issue_valid && !m_full_old) begin
          m_new = '0;
          m_new.typ = rob.issue_type; m_new.rd = rob.issue_rd; m_new.pc = rob.issue_pc;
          m_new.pred = rob.issue_pred_taken; m_new.tag = 5'(ntag);
          mq.push_back(m_new);
          ntag = (ntag % 16) + 1;
        end
      end
    end
  end

  function automatic void mquery(input logic [4:0] t, output bit known,
                                 output logic r, output logic [31:0] v);
    known = 0; r = 0; v = 0;
    if (t == 0) begin known = 1; r = 1; v = 0; end
    else if (rob.cdb_valid && rob.cdb_tag == t) begin known = 1; r = 1; v = rob.cdb_value; end
    else foreach (mq[i]) if (mq[i].tag == t) begin known = 1; r = mq[i].rdy; v = mq[i].val; end
  endfunction

  bit          qk_known;
  logic        q_r;
  logic [31:0] q_v;

  always @(negedge clk_in) begin
    if (cmp_en) begin
      chk("issue_tag", 32'(rob.issue_tag), 32'(ntag));
      chk("full", 32'(rob.full), 32'(mq.size() == 16));
      chk("empty", 32'(rob.empty), 32'(mq.size() == 0));
      chk("commit_valid", 32'(rob.commit_valid), 32'(e_cv));
      chk("commit_store", 32'(rob.commit_store), 32'(e_st));
      chk("flush", 32'(rob.flush), 32'(e_fl));
      if (e_cv) begin
        chk("commit_rd", 32'(rob.commit_rd), 32'(e_rd));
        chk("commit_tag", 32'(rob.commit_tag), 32'(e_tag));
        chk("commit_value", rob.commit_value, e_val);
      end
      if (e_fl) chk("flush_pc", rob.flush_pc, e_fpc);
      mquery(rob.query_j_tag, qk_known, q_r, q_v);
      if (qk_known) begin
        chk("query_j_ready", 32'(rob.query_j_ready), 32'(q_r));
        if (q_r) chk("query_j_value", rob.query_j_value, q_v);
      end
      mquery(rob.query_k_tag, qk_known, q_r, q_v);
      if (qk_known) begin
        chk("query_k_ready", 32'(rob.query_k_ready), 32'(q_r));
        if (q_r) chk("query_k_value", rob.query_k_value, q_v);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
    #2;
  endtask

  task automatic issue(input int t, input int rd, input logic [31:0] pc, input logic pred);
    rob.issue_valid = 1; rob.issue_type = 2'(t); rob.issue_rd = 5'(rd);
    rob.issue_pc = pc; rob.issue_pred_taken = pred;
    cyc();
    rob.issue_valid = 0;
  endtask

  task automatic cdb(input int tag, input logic [31:0] val, input logic tk, input logic [31:0] tgt);
    rob.cdb_valid = 1; rob.cdb_tag = 5'(tag); rob.cdb_value = val;
    rob.cdb_taken = tk; rob.cdb_target = tgt;
    cyc();
    rob.cdb_valid = 0;
  endtask

  task automatic expect_commit(input int rd, input int tag, input logic [31:0] val);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (rob.commit_valid) begin
        seen = 1;
        chk("lit_commit_rd", 32'(rob.commit_rd), 32'(rd));
        chk("lit_commit_tag", 32'(rob.commit_tag), 32'(tag));
        chk("lit_commit_value", rob.commit_value, val);
      end
      cyc();
    end
    if (!seen) chk("commit_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_flush(input logic [31:0] pc);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rob.flush) begin
        seen = 1;
        chk("lit_flush_pc", rob.flush_pc, pc);
      end else cyc();
    end
    if (!seen) chk("flush_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rdy_in = 1; rst_in = 1;
    rob.issue_valid = 0; rob.issue_type = 0; rob.issue_rd = 0; rob.issue_pc = 0;
    rob.issue_pred_taken = 0; rob.cdb_valid = 0; rob.cdb_tag = 0; rob.cdb_value = 0;
    rob.cdb_taken = 0; rob.cdb_target = 0; rob.query_j_tag = 0; rob.query_k_tag = 0;
    #1 rst_in = 0;
    #1;
    chk("rst_issue_tag", 32'(rob.issue_tag), 32'd1);
    chk("rst_empty", 32'(rob.empty), 32'd1);
    chk("rst_full", 32'(rob.full), 32'd0);
    cmp_en = 1;
    cyc(); cyc();
    rst_in = 1;
    cyc();

    // Reset mid-run with five entries in flight and a commit pulse showing
    for (int i = 0; i < 5; i++) issue(0, i + 1, 32'h40 + 32'(4 * i), 0);
    cdb(1, 32'h11, 0, 0);
    cyc();
    chk("pre_rst_commit_valid", 32'(rob.commit_valid), 32'd1);
    rst_in = 0;
    #1;
    chk("async_empty", 32'(rob.empty), 32'd1);
    chk("async_issue_tag", 32'(rob.issue_tag), 32'd1);
    chk("async_commit_valid", 32'(rob.commit_valid), 32'd0);
    chk("async_commit_rd", 32'(rob.commit_rd), 32'd0);
    chk("async_commit_value", rob.commit_value, 32'd0);
    chk("async_commit_tag", 32'(rob.commit_tag), 32'd0);
    cyc();
    rst_in = 1;
    cyc();

    // Out-of-order completion, in-order commit, CDB forwarding on lookup
    issue(0, 1, 32'h100, 0); issue(0, 2, 32'h104, 0); issue(0, 3, 32'h108, 0);
    cdb(3, 32'h30, 0, 0);
    cdb(1, 32'h10, 0, 0);
    rob.query_j_tag = 2;
    #1 chk("q_j_not_ready", 32'(rob.query_j_ready), 32'd0);
    rob.cdb_valid = 1; rob.cdb_tag = 2; rob.cdb_value = 32'hDEADBEEF;
    rob.query_k_tag = 1;
    #1;
    chk("q_j_fwd_ready", 32'(rob.query_j_ready), 32'd1);
    chk("q_j_fwd_value", rob.query_j_value, 32'hDEADBEEF);
    chk("q_k_ready", 32'(rob.query_k_ready), 32'd1);
    chk("q_k_value", rob.query_k_value, 32'h10);
    cyc();
    rob.cdb_valid = 0; rob.query_j_tag = 0; rob.query_k_tag = 0;
    #1 chk("q_tag0", {31'd0, rob.query_j_ready} ^ rob.query_j_value, 32'd1);
    expect_commit(1, 1, 32'h10);
    expect_commit(2, 2, 32'hDEADBEEF);
    expect_commit(3, 3, 32'h30);

    // Fill to 16, drop the 17th, wrap the tags, then drain in order
    for (int i = 0; i < 16; i++) begin
      if (i == 0) chk("fill_first_tag", 32'(rob.issue_tag), 32'd4);
      if (i == 13) chk("wrap_tag", 32'(rob.issue_tag), 32'd1);
      issue(0, (i % 30) + 1, 32'h200 + 32'(4 * i), 0);
    end
    chk("full_after_16", 32'(rob.full), 32'd1);
    issue(0, 9, 32'h2F0, 0);
    chk("drop_full", 32'(rob.full), 32'd1);
    chk("drop_issue_tag", 32'(rob.issue_tag), 32'd4);
    rob.issue_valid = 1; rob.issue_rd = 10;
    cdb(4, 32'h44, 0, 0);
    rob.issue_valid = 1;
    cdb(5, 32'h55, 0, 0);
    rob.issue_valid = 1;
    chk("after_commit_full", 32'(rob.full), 32'd0);
    chk("after_commit_tag", 32'(rob.issue_tag), 32'd4);
    cyc();
    chk("iss_com_full", 32'(rob.full), 32'd0);
    chk("iss_com_tag", 32'(rob.issue_tag), 32'd5);
    cyc();
    chk("refill_full", 32'(rob.full), 32'd1);
    chk("refill_tag", 32'(rob.issue_tag), 32'd6);
    rob.issue_valid = 0;
    for (int k = 0; k < 16; k++) cdb(((5 + k) % 16) + 1, 32'h500 + 32'(k), 0, 0);
    cyc(); cyc(); cyc();
    chk("drained_empty", 32'(rob.empty), 32'd1);
    chk("drained_tag", 32'(rob.issue_tag), 32'd6);

    // Mispredicted branch with two younger completed entries
    issue(1, 0, 32'h200, 0);
    issue(0, 7, 32'h204, 0);
    issue(0, 8, 32'h208, 0);
    cdb(7, 32'h77, 0, 0);
    cdb(8, 32'h88, 0, 0);
    cdb(6, 32'h0, 1, 32'h1000);
    rob.issue_valid = 1; rob.issue_rd = 9;
    rob.cdb_valid = 1; rob.cdb_tag = 7; rob.cdb_value = 32'h99;
    cyc();
    rob.issue_valid = 0; rob.cdb_valid = 0;
    chk("br_flush", 32'(rob.flush), 32'd1);
    chk("br_flush_pc", rob.flush_pc, 32'h1000);
    chk("br_flush_empty", 32'(rob.empty), 32'd1);
    chk("br_flush_tag", 32'(rob.issue_tag), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("no_young_commit", 32'(rob.commit_valid), 32'd0);
      chk("flush_deassert", 32'(rob.flush), 32'd0);
    end

    // Store, correctly predicted branch, reg-write, jalr
    issue(2, 0, 32'h300, 0);
    issue(1, 0, 32'h304, 1);
    issue(0, 4, 32'h308, 0);
    issue(3, 5, 32'h30C, 0);
    cdb(1, 32'h0, 0, 0);
    cdb(2, 32'h0, 1, 32'h400);
    chk("store_pulse", 32'(rob.commit_store), 32'd1);
    cdb(3, 32'h44, 0, 0);
    cdb(4, 32'h310, 0, 32'h2000);
    expect_commit(4, 3, 32'h44);
    wait_flush(32'h2000);
    chk("jalr_commit_valid", 32'(rob.commit_valid), 32'd1);
    chk("jalr_commit_rd", 32'(rob.commit_rd), 32'd5);
    chk("jalr_commit_value", rob.commit_value, 32'h310);
    cyc();
    chk("jalr_empty", 32'(rob.empty), 32'd1);

    // Predicted taken, resolved not taken: redirect to pc+4
    issue(1, 0, 32'h500, 1);
    cdb(1, 32'h0, 0, 32'h900);
    wait_flush(32'h504);
    cyc();

    // Stall with a ready head: nothing retires until rdy_in returns
    issue(0, 6, 32'h600, 0);
    cdb(1, 32'h66, 0, 0);
    rdy_in = 0; rob.query_j_tag = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_no_commit", 32'(rob.commit_valid), 32'd0);
    end
    #1 chk("stall_query", rob.query_j_value, 32'h66);
    rdy_in = 1;
    cyc();
    chk("resume_commit", 32'(rob.commit_valid), 32'd1);
    chk("resume_rd", 32'(rob.commit_rd), 32'd6);
    chk("resume_value", rob.commit_value, 32'h66);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
